// File: rtl/transmission_estimator.sv
// Streaming transmission estimator: t = MAXV - ((omega*dark) >> FW), floored at t_min,
// with frame-boundary config shadowing and per-frame min/max/count statistics of t.
module transmission_estimator #(
    parameter int DW        = 8,
    parameter int FW        = 8,
    parameter int CW        = 22,
    parameter int OMEGA_DEF = 218,
    parameter int TMIN_DEF  = 26
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          hsync,
    input  logic          vsync,
    input  logic          en,
    input  logic [DW-1:0] in_data,
    input  logic [FW:0]   cfg_omega,
    input  logic [DW-1:0] cfg_tmin,
    input  logic          cfg_bypass,
    output logic          o_hsync,
    output logic          o_vsync,
    output logic          o_en,
    output logic [DW-1:0] out_data,
    output logic [DW-1:0] stat_min,
    output logic [DW-1:0] stat_max,
    output logic [CW-1:0] stat_cnt,
    output logic          stat_valid
);

    localparam int            PW        = DW + FW + 1;
    localparam logic [DW-1:0] MAXV      = '1;
    localparam logic [FW:0]   OMEGA_ONE = {1'b1, {FW{1'b0}}};
    localparam logic [CW-1:0] CNT_MAX   = '1;

    function automatic logic [FW:0] clamp_omega(input logic [FW:0] w);
        return (w > OMEGA_ONE) ? OMEGA_ONE : w;
    endfunction

    function automatic logic [DW-1:0] floor_t(input logic [DW-1:0] t, input logic [DW-1:0] tmin);
        return (t < tmin) ? tmin : t;
    endfunction

    // Active (shadowed) configuration
    logic          vsync_d_q;
    logic [FW:0]   omega_act_q, omega_act_d;
    logic [DW-1:0] tmin_act_q, tmin_act_d;
    logic          bypass_act_q, bypass_act_d;

    // Stage 1
    logic [DW-1:0] data_p1_q, data_p1_d;
    logic [PW-1:0] prod_p1_q, prod_p1_d;
    logic [DW-1:0] tmin_p1_q, tmin_p1_d;
    logic          byp_p1_q, byp_p1_d;
    logic [2:0]    sb_p1_q, sb_p1_d;

    // Stage 2
    logic [DW-1:0] data_p2_q, data_p2_d;
    logic [DW-1:0] t_p2_q, t_p2_d;
    logic [DW-1:0] tmin_p2_q, tmin_p2_d;
    logic          byp_p2_q, byp_p2_d;
    logic [2:0]    sb_p2_q, sb_p2_d;

    // Stage 3 / outputs
    logic [DW-1:0] out_q, out_d;
    logic [2:0]    sb_p3_q, sb_p3_d;

    // Statistics
    logic          ovs_d_q;
    logic [DW-1:0] acc_min_q, acc_min_d;
    logic [DW-1:0] acc_max_q, acc_max_d;
    logic [CW-1:0] acc_cnt_q, acc_cnt_d;
    logic [DW-1:0] stat_min_q, stat_min_d;
    logic [DW-1:0] stat_max_q, stat_max_d;
    logic [CW-1:0] stat_cnt_q, stat_cnt_d;
    logic          stat_valid_q, stat_valid_d;

    logic vs_rise, ovs_rise;

    always_comb begin
        vs_rise  = vsync & ~vsync_d_q;
        ovs_rise = sb_p3_q[1] & ~ovs_d_q;

        // The pixel entering on the boundary cycle samples the pre-update config
        omega_act_d  = omega_act_q;
        tmin_act_d   = tmin_act_q;
        bypass_act_d = bypass_act_q;
        if (vs_rise) begin
            omega_act_d  = clamp_omega(cfg_omega);
            tmin_act_d   = cfg_tmin;
            bypass_act_d = cfg_bypass;
        end

        // S1: full-precision product and config snapshot
        data_p1_d = in_data;
        prod_p1_d = PW'(omega_act_q) * PW'(in_data);
        tmin_p1_d = tmin_act_q;
        byp_p1_d  = bypass_act_q;
        sb_p1_d   = {hsync, vsync, en};

        // S2: scale down and invert; clamp on omega keeps the shifted product within MAXV
        data_p2_d = data_p1_q;
        t_p2_d    = MAXV - DW'(prod_p1_q >> FW);
        tmin_p2_d = tmin_p1_q;
        byp_p2_d  = byp_p1_q;
        sb_p2_d   = sb_p1_q;

        // S3: floor or bypass
        out_d   = byp_p2_q ? data_p2_q : floor_t(t_p2_q, tmin_p2_q);
        sb_p3_d = sb_p2_q;

        stat_min_d   = stat_min_q;
        stat_max_d   = stat_max_q;
        stat_cnt_d   = stat_cnt_q;
        stat_valid_d = 1'b0;
        acc_min_d    = acc_min_q;
        acc_max_d    = acc_max_q;
        acc_cnt_d    = acc_cnt_q;
        if (ovs_rise) begin
            stat_min_d   = acc_min_q;
            stat_max_d   = acc_max_q;
            stat_cnt_d   = acc_cnt_q;
            stat_valid_d = 1'b1;
            if (sb_p3_q[0]) begin
                acc_min_d = out_q;
                acc_max_d = out_q;
                acc_cnt_d = CW'(1);
            end else begin
                acc_min_d = MAXV;
                acc_max_d = '0;
                acc_cnt_d = '0;
            end
        end else if (sb_p3_q[0]) begin
            if (out_q < acc_min_q) acc_min_d = out_q;
            if (out_q > acc_max_q) acc_max_d = out_q;
            if (acc_cnt_q != CNT_MAX) acc_cnt_d = acc_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_d_q    <= 1'b0;
            omega_act_q  <= (FW+1)'(OMEGA_DEF);
            tmin_act_q   <= DW'(TMIN_DEF);
            bypass_act_q <= 1'b0;
            data_p1_q    <= '0;
            prod_p1_q    <= '0;
            tmin_p1_q    <= '0;
            byp_p1_q     <= 1'b0;
            sb_p1_q      <= '0;
            data_p2_q    <= '0;
            t_p2_q       <= '0;
            tmin_p2_q    <= '0;
            byp_p2_q     <= 1'b0;
            sb_p2_q      <= '0;
            out_q        <= '0;
            sb_p3_q      <= '0;
            ovs_d_q      <= 1'b0;
            acc_min_q    <= MAXV;
            acc_max_q    <= '0;
            acc_cnt_q    <= '0;
            stat_min_q   <= '0;
            stat_max_q   <= '0;
            stat_cnt_q   <= '0;
            stat_valid_q <= 1'b0;
        end else begin
            vsync_d_q    <= vsync;
            omega_act_q  <= omega_act_d;
            tmin_act_q   <= tmin_act_d;
            bypass_act_q <= bypass_act_d;
            data_p1_q    <= data_p1_d;
            prod_p1_q    <= prod_p1_d;
            tmin_p1_q    <= tmin_p1_d;
            byp_p1_q     <= byp_p1_d;
            sb_p1_q      <= sb_p1_d;
            data_p2_q    <= data_p2_d;
            t_p2_q       <= t_p2_d;
            tmin_p2_q    <= tmin_p2_d;
            byp_p2_q     <= byp_p2_d;
            sb_p2_q      <= sb_p2_d;
            out_q        <= out_d;
            sb_p3_q      <= sb_p3_d;
            ovs_d_q      <= sb_p3_q[1];
            acc_min_q    <= acc_min_d;
            acc_max_q    <= acc_max_d;
            acc_cnt_q    <= acc_cnt_d;
            stat_min_q   <= stat_min_d;
            stat_max_q   <= stat_max_d;
            stat_cnt_q   <= stat_cnt_d;
            stat_valid_q <= stat_valid_d;
        end
    end

    assign o_hsync    = sb_p3_q[2];
    assign o_vsync    = sb_p3_q[1];
    assign o_en       = sb_p3_q[0];
    assign out_data   = out_q;
    assign stat_min   = stat_min_q;
    assign stat_max   = stat_max_q;
    assign stat_cnt   = stat_cnt_q;
    assign stat_valid = stat_valid_q;

endmodule

// File: tb/tb_transmission_estimator.sv
// Randomized and directed bench for transmission_estimator against a queue-based
// frame-level reference model.
module tb_transmission_estimator;

    localparam int DW   = 8;
    localparam int FW   = 8;
    localparam int CW   = 22;
    localparam int MAXV = 255;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          hsync = 1'b0, vsync = 1'b0, en = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [FW:0]   cfg_omega = 9'd218;
    logic [DW-1:0] cfg_tmin = 8'd26;
    logic          cfg_bypass = 1'b0;
    logic          o_hsync, o_vsync, o_en, stat_valid;
    logic [DW-1:0] out_data, stat_min, stat_max;
    logic [CW-1:0] stat_cnt;

    transmission_estimator #(.DW(DW), .FW(FW), .CW(CW), .OMEGA_DEF(218), .TMIN_DEF(26)) dut (
        .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync), .en(en), .in_data(in_data),
        .cfg_omega(cfg_omega), .cfg_tmin(cfg_tmin), .cfg_bypass(cfg_bypass),
        .o_hsync(o_hsync), .o_vsync(o_vsync), .o_en(o_en), .out_data(out_data),
        .stat_min(stat_min), .stat_max(stat_max), .stat_cnt(stat_cnt), .stat_valid(stat_valid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: what each pixel becomes, a 3-entry output queue, frame stats
    typedef struct {
        bit hs;
        bit vs;
        bit en;
        int d;
    } ent_t;

    ent_t pq[$];
    int m_om, m_tmin, m_byp, m_vsp, m_ovsp;
    int acc_min, acc_max, acc_cnt, st_min, st_max, st_cnt, st_v;

    function automatic int transmission(int om, int tmin, int byp, int d);
        int t;
        if (byp != 0) return d;
        t = MAXV - ((om * d) / (1 << FW));
        return (t < tmin) ? tmin : t;
    endfunction

    task automatic tick();
        ent_t o, n;
        @(posedge clk);
        if (rst) begin
            m_om = 218; m_tmin = 26; m_byp = 0; m_vsp = 0; m_ovsp = 0;
            acc_min = MAXV; acc_max = 0; acc_cnt = 0;
            st_min = 0; st_max = 0; st_cnt = 0; st_v = 0;
            pq = {};
            for (int i = 0; i < 3; i++) pq.push_back('{0, 0, 0, 0});
        end else begin
            o = pq[0];
            st_v = 0;
            if (o.vs && !m_ovsp[0]) begin
                st_min = acc_min; st_max = acc_max; st_cnt = acc_cnt; st_v = 1;
                if (o.en) begin acc_min = o.d; acc_max = o.d; acc_cnt = 1; end
                else begin acc_min = MAXV; acc_max = 0; acc_cnt = 0; end
            end else if (o.en) begin
                if (o.d < acc_min) acc_min = o.d;
                if (o.d > acc_max) acc_max = o.d;
                if (acc_cnt != (1 << CW) - 1) acc_cnt++;
            end
            m_ovsp = int'(o.vs);
            n = '{hsync, vsync, en, transmission(m_om, m_tmin, m_byp, int'(in_data))};
            if (vsync && m_vsp == 0) begin
                m_om = (cfg_omega > 9'd256) ? 256 : int'(cfg_omega);
                m_tmin = int'(cfg_tmin);
                m_byp = int'(cfg_bypass);
            end
            m_vsp = int'(vsync);
            void'(pq.pop_front());
            pq.push_back(n);
        end
        #1;
        check("o_hsync", 32'(o_hsync), 32'(pq[0].hs));
        check("o_vsync", 32'(o_vsync), 32'(pq[0].vs));
        check("o_en", 32'(o_en), 32'(pq[0].en));
        if (pq[0].en) check("out_data", 32'(out_data), 32'(pq[0].d));
        check("stat_valid", 32'(stat_valid), 32'(st_v));
        check("stat_min", 32'(stat_min), 32'(st_min));
        check("stat_max", 32'(stat_max), 32'(st_max));
        check("stat_cnt", 32'(stat_cnt), 32'(st_cnt));
    endtask

    task automatic vs_pulse();
        en = 1'b0; vsync = 1'b1; tick(); tick(); vsync = 1'b0; tick();
    endtask

    task automatic pix_chk(input string tag, input int d, input int exp);
        en = 1'b1; in_data = DW'(d); tick();
        en = 1'b0; tick(); tick();
        check(tag, 32'(out_data), 32'(exp));
    endtask

    task automatic rand_frame(input int lines, input int ppl);
        cfg_omega  = 9'($urandom_range(0, 300));
        cfg_tmin   = 8'($urandom_range(0, 80));
        cfg_bypass = ($urandom_range(0, 3) == 0);
        vs_pulse();
        for (int l = 0; l < lines; l++) begin
            hsync = 1'b1; en = 1'b0; tick(); hsync = 1'b0;
            for (int p = 0; p < ppl; p++) begin
                en = ($urandom_range(0, 3) != 0);
                in_data = 8'($urandom);
                tick();
            end
            en = 1'b0; tick();
        end
    endtask

    initial begin
        int lmin, lmax, v, waited;
        rst = 1'b1; tick(); tick(); tick();
        check("rst_out_data", 32'(out_data), 0);
        check("rst_o_en", 32'(o_en), 0);
        rst = 1'b0;

        // Reset defaults
        pix_chk("def_200", 200, 85);
        pix_chk("def_255", 255, 38);

        // Floor
        cfg_omega = 9'd256; cfg_tmin = 8'd26; cfg_bypass = 1'b0;
        vs_pulse();
        pix_chk("floor_255", 255, 26);
        pix_chk("floor_0", 0, 255);

        // Clamp and shadowing
        cfg_omega = 9'd218; vs_pulse();
        cfg_omega = 9'd300;
        pix_chk("mid_frame_cfg", 100, 170);
        vsync = 1'b1;
        pix_chk("rise_cycle_old", 100, 170);
        pix_chk("after_rise_clamp", 100, 155);
        vsync = 1'b0; tick();

        // Random frames
        for (int f = 0; f < 5; f++) rand_frame(3, 40);

        // Bypass stream
        cfg_bypass = 1'b1; vs_pulse();
        for (int i = 0; i < 258; i++) begin
            en = (i < 256); in_data = 8'(i); tick();
            if (i >= 2) check("bypass_seq", 32'(out_data), 32'(i - 2));
        end
        en = 1'b0;

        // Stats frame, 640x4, bypass so out_data equals input
        vs_pulse();
        lmin = MAXV; lmax = 0;
        for (int l = 0; l < 4; l++) begin
            hsync = 1'b1; en = 1'b0; tick(); hsync = 1'b0;
            for (int p = 0; p < 640; p++) begin
                v = $urandom_range(10, 250);
                if (v < lmin) lmin = v;
                if (v > lmax) lmax = v;
                en = 1'b1; in_data = 8'(v); tick();
            end
        end
        vsync = 1'b1; en = 1'b1; in_data = 8'd5; tick();
        en = 1'b0; tick(); vsync = 1'b0;
        waited = 0;
        while (!stat_valid && waited < 10) begin tick(); waited++; end
        if (!stat_valid) check("stat_timeout", 0, 1);
        else begin
            check("frame_cnt", 32'(stat_cnt), 2560);
            check("frame_min", 32'(stat_min), 32'(lmin));
            check("frame_max", 32'(stat_max), 32'(lmax));
        end
        for (int p = 0; p < 3; p++) begin en = 1'b1; in_data = 8'(100 + p); tick(); end
        en = 1'b0;
        vsync = 1'b1; tick(); tick(); vsync = 1'b0;
        waited = 0;
        while (!stat_valid && waited < 10) begin tick(); waited++; end
        if (!stat_valid) check("stat_timeout2", 0, 1);
        else begin
            check("boundary_cnt", 32'(stat_cnt), 4);
            check("boundary_min", 32'(stat_min), 5);
            check("boundary_max", 32'(stat_max), 102);
        end
        cfg_bypass = 1'b0;

        // Reset mid-frame
        cfg_omega = 9'd100; cfg_tmin = 8'd0; vs_pulse();
        hsync = 1'b1; tick(); hsync = 1'b0;
        for (int p = 0; p < 5; p++) begin en = 1'b1; in_data = 8'($urandom); tick(); end
        rst = 1'b1; tick(); rst = 1'b0; en = 1'b0;
        check("midrst_out", 32'(out_data), 0);
        check("midrst_valid", 32'(stat_valid), 0);
        check("midrst_cnt", 32'(stat_cnt), 0);
        pix_chk("midrst_default", 200, 85);
        rand_frame(4, 50);
        vs_pulse(); tick(); tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
